// File: rtl/conv_window_sched.sv
// 3x3 convolution read scheduler: walks a window over the feature map, drives
// memory_part read addresses and bank select, and tags the returned data.
module conv_window_sched #(
  parameter int width    = 80,
  parameter int height   = 8,
  parameter int width_b  = 7,
  parameter int height_b = 3,
  parameter int max_step = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [width_b-1:0]      fm_w,
  input  logic [2:0]              n_step,
  input  logic                    hold,
  output logic [width_b*9-1:0]    readi_w,
  output logic [height_b*9-1:0]   readi_h,
  output logic [2:0]              step,
  output logic                    win_valid,
  output logic [width_b-1:0]      win_x,
  output logic [height_b-1:0]     win_y,
  output logic [2:0]              win_step,
  output logic                    last,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [width_b-1:0]  fm_max = width_b'(width - 9 * max_step);
  localparam logic [height_b-1:0] y_last = height_b'(height - 3);

  state_t              state;
  logic [width_b-1:0]  fm_w_q;
  logic [2:0]          n_step_q;
  logic [width_b-1:0]  x, x_nx;
  logic [height_b-1:0] y, y_nx;
  logic [2:0]          s_nx;
  logic                x_wrap, y_wrap, final_win, fire, cfg_ok;

  function automatic logic [width_b*9-1:0] pack_w(input logic [width_b-1:0] bx);
    logic [width_b*9-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[(8-k)*width_b +: width_b] = bx + width_b'(k % 3);
    return r;
  endfunction

  function automatic logic [height_b*9-1:0] pack_h(input logic [height_b-1:0] by);
    logic [height_b*9-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[(8-k)*height_b +: height_b] = by + height_b'(k / 3);
    return r;
  endfunction

  assign cfg_ok    = (fm_w >= width_b'(3)) && (fm_w <= fm_max) &&
                     (n_step != 3'd0) && (n_step <= 3'(max_step));
  assign fire      = (state == RUN) && !hold;
  assign x_wrap    = (x == fm_w_q - width_b'(3));
  assign y_wrap    = (y == y_last);
  assign final_win = x_wrap && y_wrap && (step == n_step_q - 3'd1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    x_nx = x + width_b'(1);
    y_nx = y;
    s_nx = step;
    if (x_wrap) begin
      x_nx = '0;
      y_nx = y_wrap ? '0 : y + height_b'(1);
      if (y_wrap) s_nx = step + 3'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fm_w_q    <= '0;
      n_step_q  <= '0;
      x         <= '0;
      y         <= '0;
      step      <= '0;
      readi_w   <= '0;
      readi_h   <= '0;
      win_valid <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
      win_step  <= '0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      last      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state    <= RUN;
              busy     <= 1'b1;
              fm_w_q   <= fm_w;
              n_step_q <= n_step;
              x        <= '0;
              y        <= '0;
              step     <= '0;
              readi_w  <= pack_w('0);
              readi_h  <= pack_h('0);
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fire) begin
            // Tag stage lines up with memory_part's registered read data.
            win_valid <= 1'b1;
            win_x     <= x;
            win_y     <= y;
            win_step  <= step;
            if (final_win) begin
              last  <= 1'b1;
              done  <= 1'b1;
              state <= DRAIN;
            end else begin
              x       <= x_nx;
              y       <= y_nx;
              step    <= s_nx;
              readi_w <= pack_w(x_nx);
              readi_h <= pack_h(y_nx);
            end
          end
        end
        DRAIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed self-checking bench for conv_window_sched: reset, basic, multi-bank,
// hold, bad-config, busy/return-cycle start and abort scenarios.
module tb_conv_window_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  fm_w = '0;
  logic [2:0]  n_step = '0;
  logic        hold = 1'b0;
  logic [62:0] readi_w;
  logic [26:0] readi_h;
  logic [2:0]  step;
  logic        win_valid;
  logic [6:0]  win_x;
  logic [2:0]  win_y;
  logic [2:0]  win_step;
  logic        last, busy, done, err;

  int total = 0;
  int bad = 0;

  conv_window_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fm_w(fm_w), .n_step(n_step),
    .hold(hold), .readi_w(readi_w), .readi_h(readi_h), .step(step),
    .win_valid(win_valid), .win_x(win_x), .win_y(win_y), .win_step(win_step),
    .last(last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_readi_w"}, 64'(readi_w), 64'd0);
    check({tag, "_readi_h"}, 64'(readi_h), 64'd0);
    check({tag, "_step"}, 64'(step), 64'd0);
    check({tag, "_tags"}, 64'({win_x, win_y, win_step}), 64'd0);
    check({tag, "_flags"}, 64'({win_valid, last, busy, done, err}), 64'd0);
  endtask

  // One pass from start to done. hlo..hhi: hold cycles; bsc: cycle for an ignored
  // start while busy; drain_start: raise a valid start during the done cycle.
  task automatic run_pass(input string tag, input int fw, input int ns,
                          input int hlo, input int hhi, input int done_cyc,
                          input bit chk_addr, input int bsc, input bit drain_start);
    int nx, per_bank, n_win, seen, cyc, es, ey, ex;
    logic [2:0] prev_step;
    bit got_done;
    nx = fw - 2;
    per_bank = nx * 6;
    n_win = per_bank * ns;
    seen = 0;
    got_done = 0;
    fm_w = 7'(fw);
    n_step = 3'(ns);
    start = 1'b1;
    tick();
    cyc = 1;
    start = 1'b0;
    check({tag, "_busy_on"}, 64'(busy), 64'd1);
    if (chk_addr) begin
      check({tag, "_first_w"}, 64'(readi_w),
            64'({7'd0, 7'd1, 7'd2, 7'd0, 7'd1, 7'd2, 7'd0, 7'd1, 7'd2}));
      check({tag, "_first_h"}, 64'(readi_h),
            64'({3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2}));
    end
    prev_step = step;
    while (!got_done && cyc < 400) begin
      hold = (cyc >= hlo && cyc <= hhi);
      if (cyc == bsc) begin
        start = 1'b1;
        fm_w = 7'd2;
      end
      if (bsc > 0 && cyc == bsc + 1) begin
        start = 1'b0;
        check({tag, "_busy_start_err"}, 64'(err), 64'd0);
        check({tag, "_busy_start_busy"}, 64'(busy), 64'd1);
      end
      if (cyc > hlo && cyc <= hhi + 1)
        check({tag, "_hold_novalid"}, 64'(win_valid), 64'd0);
      if (chk_addr && cyc == done_cyc - 1) begin
        check({tag, "_final_w"}, 64'(readi_w),
              64'({7'd2, 7'd3, 7'd4, 7'd2, 7'd3, 7'd4, 7'd2, 7'd3, 7'd4}));
        check({tag, "_final_h"}, 64'(readi_h),
              64'({3'd5, 3'd5, 3'd5, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7}));
      end
      if (win_valid) begin
        es = seen / per_bank;
        ey = (seen % per_bank) / nx;
        ex = (seen % per_bank) % nx;
        check({tag, "_win_pos"}, 64'({win_step, win_y, win_x}), 64'({3'(es), 3'(ey), 7'(ex)}));
        check({tag, "_step_prev"}, 64'(prev_step), 64'(es));
        check({tag, "_last"}, 64'(last), 64'(seen == n_win - 1));
        check({tag, "_done"}, 64'(done), 64'(seen == n_win - 1));
        seen++;
      end else if (done) begin
        check({tag, "_stray_done"}, 64'(done), 64'd0);
      end
      if (done) begin
        got_done = 1;
        check({tag, "_done_cyc"}, 64'(cyc), 64'(done_cyc));
        if (drain_start) begin
          fm_w = 7'd5;
          n_step = 3'd1;
          start = 1'b1;
        end
      end else begin
        prev_step = step;
        tick();
        cyc++;
      end
    end
    check({tag, "_done_seen"}, 64'(got_done), 64'd1);
    check({tag, "_windows"}, 64'(seen), 64'(n_win));
    hold = 1'b0;
    tick();
    start = 1'b0;
    check({tag, "_busy_off"}, 64'(busy), 64'd0);
    check({tag, "_post_flags"}, 64'({win_valid, last, done, err}), 64'd0);
    if (drain_start) begin
      tick();
      check({tag, "_drain_start_ignored"}, 64'(busy), 64'd0);
    end
    tick();
  endtask

  task automatic bad_cfg(input string tag, input int fw, input int ns);
    fm_w = 7'(fw);
    n_step = 3'(ns);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_err"}, 64'(err), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    tick();
    check({tag, "_err_clr"}, 64'({err, busy}), 64'd0);
  endtask

  initial begin
    #20;
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    tick();
    check_all_zero("rst_rel");

    run_pass("basic", 5, 1, 0, -1, 19, 1'b1, 0, 1'b0);
    run_pass("multi", 3, 3, 0, -1, 19, 1'b0, 0, 1'b0);
    run_pass("hold", 5, 1, 5, 7, 22, 1'b1, 0, 1'b0);
    run_pass("busy_start", 5, 1, 0, -1, 19, 1'b0, 3, 1'b1);

    bad_cfg("bad_fw2", 2, 1);
    bad_cfg("bad_ns0", 5, 0);
    bad_cfg("bad_ns7", 5, 7);
    bad_cfg("bad_fw27", 27, 1);

    // Abort: reset asserted at cycle 10 of a pass.
    fm_w = 7'd5;
    n_step = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("abort_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (3) tick();
    check("abort_no_done", 64'({done, busy}), 64'd0);
    rst_n = 1'b1;
    tick();
    run_pass("after_abort", 5, 1, 0, -1, 19, 1'b1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_window_sched.md
Name: conv_window_sched

Overview:
- Scheduler that drives the read side of memory_part for 3x3 convolution.
- Walks a 3x3 window over the feature-map region of the buffer and emits the nine packed (w,h) read addresses each cycle.
- Selects the weight bank via step and tags the returned fmap/weight data with valid, position and last flags for the PE array.
- Sits between the top-level control and memory_part; the write/load path is out of scope.

Parameters:
- width, 80, buffer columns (must match memory_part)
- height, 8, buffer rows (must match memory_part)
- width_b, 7, column address bits
- height_b, 3, row address bits
- max_step, 6, number of weight banks (step codes 0..max_step-1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a pass; sampled in IDLE only
- fm_w  in  width_b  feature-map width in columns; fmap occupies columns 0..fm_w-1, rows 0..height-1
- n_step  in  3  number of weight banks to sweep, 1..max_step
- hold  in  1  stall: freezes the address/step/counters while high
- readi_w  out  width_b*9  packed column addresses, window element 0 in MSBs
- readi_h  out  height_b*9  packed row addresses, same order as readi_w
- step  out  3  weight bank select to memory_part
- win_valid  out  1  fmap/weight outputs of memory_part are valid this cycle
- win_x  out  width_b  window x of the data flagged by win_valid
- win_y  out  height_b  window y of the data flagged by win_valid
- win_step  out  3  bank of the data flagged by win_valid
- last  out  1  with win_valid: final window of the pass
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse marking pass completion
- err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, all counters 0. Reset mid-pass aborts it; no done is issued.
- Window element k = 3*dy+dx, with dx,dy in 0..2. Element k address is w = x+dx, h = y+dy. Element 0 maps to readi_w[width_b*9-1 -: width_b].
- Registered outputs: readi_w, readi_h and step are registers, driven from counters x, y, s.
- States:
  - IDLE: start=1 with valid config -> RUN; latch fm_w and n_step; x=y=s=0; busy=1 from the next cycle.
  - Invalid config (fm_w<3, fm_w>width-9*max_step, n_step=0 or n_step>max_step): err pulses next cycle, stay IDLE.
  - RUN: fire = ~hold. On fire the current address is consumed.
  - Counter advance on fire: x increments. At x=fm_w-3, x wraps to 0 and y increments. At y=height-3 with x wrapped, y wraps to 0 and s increments. Scan order: x fastest, then y, then s.
  - Fire on x=fm_w-3, y=height-3, s=n_step-1 -> DRAIN.
  - DRAIN: one cycle, no fire; -> IDLE.
- hold=1 in RUN: addresses and counters stay constant; memory_part re-reads the same locations; no win_valid follows.
- Latency: memory_part registers its reads, so tag pipeline stage = fire delayed 1 cycle. win_valid, win_x, win_y, win_step and last are all driven from that stage.
- last=1 only on the win_valid cycle of the final fire.
- done pulses in the same cycle as last. busy drops the cycle after done.
- Window count per pass: (fm_w-2)*(height-2)*n_step.
- start while busy: ignored, no err.
- start on the same cycle the FSM returns to IDLE: ignored; start is accepted only when IDLE is the registered state.
- In IDLE, readi_w, readi_h and step hold their last values; win_valid=0.

Test Plan:
- Reset values: rst_n low, then release -> every output 0, busy=0.
- Basic pass: fm_w=5, n_step=1, hold=0, start at cycle 0.
  - Fires at cycles 1..18; win_valid at cycles 2..19.
  - First readi_w = {0,1,2,0,1,2,0,1,2}, readi_h = {0,0,0,1,1,1,2,2,2}.
  - Final readi_w = {2,3,4,2,3,4,2,3,4}, readi_h = {5,5,5,6,6,6,7,7,7}.
  - last=done=1 at cycle 19; busy=0 at cycle 20.
- Multi-bank: fm_w=3, n_step=3 -> 18 win_valid pulses. win_step = 0 for pulses 1-6, 1 for 7-12, 2 for 13-18. step output tracks s one cycle earlier.
- Hold: in the basic pass, hold=1 for cycles 5..7 -> addresses frozen, no win_valid at cycles 6..8, done at cycle 22, still 18 windows.
- Bad config: fm_w=2 (or n_step=0, or n_step=7) with start -> err pulse, busy stays 0. start while busy -> ignored.
- Abort: rst_n low mid-pass (cycle 10) -> all outputs 0 immediately, no done. A fresh start then runs a full 18-window pass.
